// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IFU/LSU requesters, the mem_arbiter and main memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ifu_req_in;
    logic [ADDR_W-1:0] ifu_addr_in;
    logic              ifu_gnt_out;
    logic              ifu_valid_out;
    logic [DATA_W-1:0] ifu_data_out;

    logic              lsu_req_in;
    logic [ADDR_W-1:0] lsu_addr_in;
    logic              lsu_gnt_out;
    logic              lsu_valid_out;
    logic [DATA_W-1:0] lsu_data_out;

    logic [ADDR_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_data_in;

    modport slave (
        input  ifu_req_in, ifu_addr_in,
        input  lsu_req_in, lsu_addr_in,
        input  mem_data_in,
        output ifu_gnt_out, ifu_valid_out, ifu_data_out,
        output lsu_gnt_out, lsu_valid_out, lsu_data_out,
        output mem_addr_out
    );

    modport master (
        output ifu_req_in, ifu_addr_in,
        output lsu_req_in, lsu_addr_in,
        output mem_data_in,
        input  ifu_gnt_out, ifu_valid_out, ifu_data_out,
        input  lsu_gnt_out, lsu_valid_out, lsu_data_out,
        input  mem_addr_out
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (IFU/LSU) read arbiter in front of a single combinational memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed LSU-over-IFU priority.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1      // legal range 1..15
) (
    input  logic          clk_in,
    input  logic          rst_in,
    mem_arbiter_if.slave  bus
);

    typedef enum logic { IDLE, BUSY } state_e;
    typedef enum logic { OWN_LSU, OWN_IFU } owner_e;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_e            state;
    owner_e            owner;
    owner_e            pick;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              ifu_gnt_q;
    logic              ifu_valid_q;
    logic [DATA_W-1:0] ifu_data_q;
    logic              lsu_gnt_q;
    logic              lsu_valid_q;
    logic [DATA_W-1:0] lsu_data_q;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        pick = OWN_LSU;
`ifdef MEM_ARB_RR_EN
        if (bus.ifu_req_in && bus.lsu_req_in)
            pick = (owner == OWN_LSU) ? OWN_IFU : OWN_LSU;
        else if (bus.ifu_req_in)
            pick = OWN_IFU;
`else
        if (bus.ifu_req_in && !bus.lsu_req_in)
            pick = OWN_IFU;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            owner       <= OWN_LSU;
            cnt         <= '0;
            mem_addr_q  <= '0;
            ifu_gnt_q   <= 1'b0;
            ifu_valid_q <= 1'b0;
            ifu_data_q  <= '0;
            lsu_gnt_q   <= 1'b0;
            lsu_valid_q <= 1'b0;
            lsu_data_q  <= '0;
        end else begin
            // gnt and valid are single-cycle pulses unless re-asserted below
            ifu_gnt_q   <= 1'b0;
            lsu_gnt_q   <= 1'b0;
            ifu_valid_q <= 1'b0;
            lsu_valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.ifu_req_in || bus.lsu_req_in) begin
                        owner <= pick;
                        cnt   <= LAT_M1;
                        state <= BUSY;
                        if (pick == OWN_IFU) begin
                            mem_addr_q <= bus.ifu_addr_in;
                            ifu_gnt_q  <= 1'b1;
                        end else begin
                            mem_addr_q <= bus.lsu_addr_in;
                            lsu_gnt_q  <= 1'b1;
                        end
                    end
                end

                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                        if (owner == OWN_IFU) begin
                            ifu_data_q  <= bus.mem_data_in;
                            ifu_valid_q <= 1'b1;
                        end else begin
                            lsu_data_q  <= bus.mem_data_in;
                            lsu_valid_q <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr_out  = mem_addr_q;
    assign bus.ifu_gnt_out   = ifu_gnt_q;
    assign bus.ifu_valid_out = ifu_valid_q;
    assign bus.ifu_data_out  = ifu_data_q;
    assign bus.lsu_gnt_out   = lsu_gnt_q;
    assign bus.lsu_valid_out = lsu_valid_q;
    assign bus.lsu_data_out  = lsu_data_q;

    // Protocol invariants: single owner per grant, no gnt/valid overlap, stable address.
    a_gnt_onehot: assert property (@(posedge clk_in) disable iff (rst_in)
        !(ifu_gnt_q && lsu_gnt_q));
    a_ifu_excl: assert property (@(posedge clk_in) disable iff (rst_in)
        !(ifu_gnt_q && ifu_valid_q));
    a_lsu_excl: assert property (@(posedge clk_in) disable iff (rst_in)
        !(lsu_gnt_q && lsu_valid_q));
    a_addr_stable: assert property (@(posedge clk_in) disable iff (rst_in)
        (state == BUSY && $past(state) == BUSY) |-> (mem_addr_q == $past(mem_addr_q)));

endmodule
